ook_burst_scheduler: RTL



---
 rtl/ook_sched_pkg.sv | 23 ++
 rtl/ook_burst_scheduler_if.sv | 16 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/ook_burst_scheduler.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ook_sched_pkg.sv
// ook_sched_pkg: shared types and constants for the OOK packet-burst scheduler.
//   state_t      - burst FSM state
//   *_DEF        - default burst shape for the fan-controller link
//   CMD_*        - command codes carried by request sources
package ook_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int BURST_COUNT_DEF     = 220;
    localparam int PACKET_INTERVAL_DEF = 158400;
    localparam int TAIL_CMD_DEF        = 7;
    localparam int TAIL_COUNT_DEF      = 3;

    localparam logic [2:0] CMD_SPEED0 = 3'd0;
    localparam logic [2:0] CMD_SPEED1 = 3'd1;
    localparam logic [2:0] CMD_SPEED2 = 3'd2;
    localparam logic [2:0] CMD_SPEED3 = 3'd3;
    localparam logic [2:0] CMD_LIGHT  = 3'd4;

endpackage

// File: rtl/ook_burst_scheduler_if.sv
// ook_burst_scheduler_if: request bundle from NUM_SRC command sources.
//   req_valid - per-source request
//   req_cmd   - per-source command, source i at [i*CMD_W +: CMD_W]
//   req_ready - per-source accept (at most one bit set)
// master: the request sources; slave: the scheduler.
interface ook_burst_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int CMD_W   = 3
);
    logic [NUM_SRC-1:0]       req_valid;
    logic [NUM_SRC*CMD_W-1:0] req_cmd;
    logic [NUM_SRC-1:0]       req_ready;

    modport master (output req_valid, output req_cmd, input req_ready);
    modport slave  (input req_valid, input req_cmd, output req_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read.
//   clk, reset     - clock, synchronous active-high reset
//   flush          - synchronous empty (pointers and count cleared)
//   push/push_data - write at tail; caller must not push when full
//   pop            - advance head; caller must not pop when empty
//   head           - current head entry
//   full, empty    - status
//   count          - number of stored entries
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is not reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ook_burst_scheduler.sv
// ook_burst_scheduler: fixed-priority command intake, command queue and
// burst replay for the OOK packet generator.
//   clk, reset    - clock, synchronous active-high reset
//   req           - request bundle (slave side): lowest index wins
//   abort         - one-cycle strobe: flush queue, cut burst to its tail
//   start_packet  - one-cycle packet start pulse
//   cur_cmd       - command for the packet started by start_packet
//   busy          - burst in progress
//   queue_count   - queued commands
// Each popped command becomes BURST_COUNT pulses PACKET_INTERVAL apart;
// the last TAIL_COUNT pulses carry TAIL_CMD.
module ook_burst_scheduler
    import ook_sched_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int CMD_W           = 3,
    parameter int BURST_COUNT     = BURST_COUNT_DEF,
    parameter int TAIL_COUNT      = TAIL_COUNT_DEF,
    parameter int TAIL_CMD        = TAIL_CMD_DEF,
    parameter int IDLE_CMD        = 7,
    parameter int PACKET_INTERVAL = PACKET_INTERVAL_DEF,
    parameter int QUEUE_DEPTH     = 4,
    localparam int QCW = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    ook_burst_scheduler_if.slave   req,
    input  logic                   abort,
    output logic                   start_packet,
    output logic [CMD_W-1:0]       cur_cmd,
    output logic                   busy,
    output logic [QCW-1:0]         queue_count
);

    localparam int TW = $clog2(PACKET_INTERVAL);
    localparam int PW = $clog2(BURST_COUNT + 1);

    localparam logic [TW-1:0]    TIMER_RELOAD = TW'(PACKET_INTERVAL - 1);
    localparam logic [PW-1:0]    PKT_LOAD     = PW'(BURST_COUNT);
    localparam logic [PW-1:0]    PKT_TAIL     = PW'(TAIL_COUNT);
    localparam logic [CMD_W-1:0] TAIL_C       = CMD_W'(TAIL_CMD);
    localparam logic [CMD_W-1:0] IDLE_C       = CMD_W'(IDLE_CMD);

    // ---------------- arbitration ----------------
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] accept;
    logic [CMD_W-1:0]   push_cmd;
    logic               push;
    logic               pop;
    logic               q_full;
    logic               q_empty;
    logic [CMD_W-1:0]   q_head;

    // x & -x isolates the lowest set bit: the highest-priority requester.
    assign grant  = req.req_valid & (~req.req_valid + NUM_SRC'(1));
    assign accept = (q_full || abort || reset) ? '0 : grant;
    assign push   = |accept;

    assign req.req_ready = accept;

    always_comb begin
        push_cmd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                push_cmd = req.req_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    // ---------------- command queue ----------------
    sync_fifo #(
        .WIDTH(CMD_W),
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (abort),
        .push     (push),
        .push_data(push_cmd),
        .pop      (pop),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (queue_count)
    );

    // ---------------- burst FSM ----------------
    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [PW-1:0]    pkt_left, pkt_n, pkt_eff;
    logic [CMD_W-1:0] cmd_reg, cmd_n;
    logic [CMD_W-1:0] cur_n;
    logic             start_n;
    logic             busy_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            pkt_left     <= '0;
            cmd_reg      <= '0;
            start_packet <= 1'b0;
            cur_cmd      <= IDLE_C;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            pkt_left     <= pkt_n;
            cmd_reg      <= cmd_n;
            start_packet <= start_n;
            cur_cmd      <= cur_n;
            busy         <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        pkt_n   = pkt_left;
        cmd_n   = cmd_reg;
        cur_n   = cur_cmd;
        start_n = 1'b0;
        busy_n  = busy;
        pop     = 1'b0;

        // Abort only shortens the packets still to be issued; applying it
        // before the issue decision makes a coinciding packet the first tail.
        pkt_eff = (abort && (pkt_left > PKT_TAIL)) ? PKT_TAIL : pkt_left;

        case (state)
            IDLE: begin
                if (busy) begin
                    // First cycle back in IDLE: drop busy before the next pop,
                    // so consecutive bursts show a visible busy gap.
                    busy_n = 1'b0;
                    cur_n  = IDLE_C;
                end else if (!q_empty && !abort) begin
                    pop     = 1'b1;
                    cmd_n   = q_head;
                    pkt_n   = PKT_LOAD;
                    timer_n = '0;
                    busy_n  = 1'b1;
                    state_n = BURST;
                end
            end
            BURST: begin
                if (timer != '0) begin
                    timer_n = timer - TW'(1);
                    pkt_n   = pkt_eff;
                end else if (pkt_eff != '0) begin
                    start_n = 1'b1;
                    cur_n   = (pkt_eff <= PKT_TAIL) ? TAIL_C : cmd_reg;
                    pkt_n   = pkt_eff - PW'(1);
                    timer_n = TIMER_RELOAD;
                end else begin
                    // Reached only after a full trailing interval.
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
